// File: rtl/seg7_scan_driver_pkg.sv
// Shared 7-segment definitions: segment patterns {a,b,c,d,e,f,g,dp} and digit nibble width.
package seg7_scan_driver_pkg;

  localparam int unsigned NIB_W = 4;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_0 = 8'b1111_1100;
  localparam logic [7:0] SEG_1 = 8'b0110_0000;
  localparam logic [7:0] SEG_2 = 8'b1101_1010;
  localparam logic [7:0] SEG_3 = 8'b1111_0010;
  localparam logic [7:0] SEG_4 = 8'b0110_0110;
  localparam logic [7:0] SEG_5 = 8'b1011_0110;
  localparam logic [7:0] SEG_6 = 8'b1011_1110;
  localparam logic [7:0] SEG_7 = 8'b1110_0000;
  localparam logic [7:0] SEG_8 = 8'b1111_1110;
  localparam logic [7:0] SEG_9 = 8'b1111_0110;
  localparam logic [7:0] SEG_A = 8'b1110_1110;
  localparam logic [7:0] SEG_B = 8'b0011_1110;
  localparam logic [7:0] SEG_C = 8'b0001_1010;
  localparam logic [7:0] SEG_D = 8'b0111_1010;
  localparam logic [7:0] SEG_E = 8'b1001_1110;
  localparam logic [7:0] SEG_F = 8'b1000_1110;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to 7-segment {a..g} decoder, active-high.
module hex_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [NIB_W-1:0] hex,
  output logic [6:0]       seg7
);

  logic [7:0] pat;

  always_comb begin
    pat = SEG_BLANK;
    case (hex)
      4'h0:    pat = SEG_0;
      4'h1:    pat = SEG_1;
      4'h2:    pat = SEG_2;
      4'h3:    pat = SEG_3;
      4'h4:    pat = SEG_4;
      4'h5:    pat = SEG_5;
      4'h6:    pat = SEG_6;
      4'h7:    pat = SEG_7;
      4'h8:    pat = SEG_8;
      4'h9:    pat = SEG_9;
      4'hA:    pat = SEG_A;
      4'hB:    pat = SEG_B;
      4'hC:    pat = SEG_C;
      4'hD:    pat = SEG_D;
      4'hE:    pat = SEG_E;
      default: pat = SEG_F;
    endcase
  end

  assign seg7 = pat[7:1];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver with prescaled scan, frame-synchronous shadow load,
// leading-zero blanking and per-digit decimal points. All outputs registered.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int unsigned NDIG     = 4,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [NIB_W*NDIG-1:0] data,
  input  logic [NDIG-1:0]       dp_in,
  input  logic                  lzb,
  output logic [7:0]            seg,
  output logic [NDIG-1:0]       digit_sel,
  output logic                  frame,
  output logic                  pending
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned IW = $clog2(NDIG);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NDIG - 1);

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  run_q, run_d;
  logic [NIB_W*NDIG-1:0] disp_q, disp_d, shad_q, shad_d;
  logic [NDIG-1:0]       disp_dp_q, disp_dp_d, shad_dp_q, shad_dp_d;
  logic                  pending_q, pending_d;
  logic [7:0]            seg_q, seg_d;
  logic [NDIG-1:0]       digit_sel_q, digit_sel_d;
  logic                  frame_q, frame_d;
  logic                  wrap;

  logic [NIB_W-1:0] digs [NDIG];
  logic [NIB_W-1:0] nib;
  logic [6:0]       dec_seg;
  logic [NDIG-1:0]  blank;

  // Scan counter and display/shadow register next state.
  always_comb begin
    presc_d   = presc_q;
    idx_d     = idx_q;
    run_d     = run_q;
    disp_d    = disp_q;
    disp_dp_d = disp_dp_q;
    shad_d    = shad_q;
    shad_dp_d = shad_dp_q;
    pending_d = pending_q;
    wrap      = 1'b0;

    if (!en) begin
      presc_d = '0;
      idx_d   = '0;
      run_d   = 1'b0;
      if (load) begin
        disp_d    = data;
        disp_dp_d = dp_in;
        pending_d = 1'b0;
      end
    end else begin
      run_d = 1'b1;
      if (!run_q) begin
        presc_d = '0;
        idx_d   = '0;
      end else if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        if (idx_q == IDX_MAX) begin
          idx_d = '0;
          wrap  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end

      // A LOAD landing on the wrap edge bypasses the shadow entirely.
      if (wrap && load) begin
        disp_d    = data;
        disp_dp_d = dp_in;
        pending_d = 1'b0;
      end else if (wrap && pending_q) begin
        disp_d    = shad_q;
        disp_dp_d = shad_dp_q;
        pending_d = 1'b0;
      end else if (load) begin
        shad_d    = data;
        shad_dp_d = dp_in;
        pending_d = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NDIG; i++) begin
      digs[i] = disp_d[i*NIB_W +: NIB_W];
    end
  end

  assign nib = digs[idx_d];

  hex_to_seg7 u_dec (
    .hex  (nib),
    .seg7 (dec_seg)
  );

  // Digit i is blank when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    logic zero_above;
    blank      = '0;
    zero_above = lzb;
    for (int i = NDIG - 1; i > 0; i--) begin
      zero_above = zero_above && (digs[i] == '0);
      blank[i]   = zero_above;
    end
  end

  always_comb begin
    seg_d       = SEG_BLANK;
    digit_sel_d = '0;
    frame_d     = wrap;
    if (en) begin
      seg_d       = {blank[idx_d] ? 7'b0 : dec_seg, disp_dp_d[idx_d]};
      digit_sel_d = NDIG'(1) << idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      idx_q       <= '0;
      run_q       <= 1'b0;
      disp_q      <= '0;
      disp_dp_q   <= '0;
      shad_q      <= '0;
      shad_dp_q   <= '0;
      pending_q   <= 1'b0;
      seg_q       <= SEG_BLANK;
      digit_sel_q <= '0;
      frame_q     <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      run_q       <= run_d;
      disp_q      <= disp_d;
      disp_dp_q   <= disp_dp_d;
      shad_q      <= shad_d;
      shad_dp_q   <= shad_dp_d;
      pending_q   <= pending_d;
      seg_q       <= seg_d;
      digit_sel_q <= digit_sel_d;
      frame_q     <= frame_d;
    end
  end

  assign seg       = seg_q;
  assign digit_sel = digit_sel_q;
  assign frame     = frame_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios plus randomized traffic
// against a cycle-count based reference model.
module tb_seg7_scan_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned SD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, load, lzb;
  logic [15:0]   data;
  logic [3:0]    dp_in;
  logic [7:0]    seg;
  logic [3:0]    digit_sel;
  logic          frame, pending;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state.
  logic [6:0]  tbl [16];
  int          cnt;
  logic [15:0] m_disp, m_shad;
  logic [3:0]  m_dp, m_sdp;
  logic        m_pend;
  logic [7:0]  e_seg;
  logic [3:0]  e_sel;
  logic        e_frame;

  seg7_scan_driver #(
    .NDIG     (ND),
    .SCAN_DIV (SD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .data      (data),
    .dp_in     (dp_in),
    .lzb       (lzb),
    .seg       (seg),
    .digit_sel (digit_sel),
    .frame     (frame),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    cnt = -1; m_disp = '0; m_shad = '0; m_dp = '0; m_sdp = '0; m_pend = 1'b0;
    e_seg = '0; e_sel = '0; e_frame = 1'b0;
  endtask

  // Apply one clock edge's worth of behaviour using the inputs present at that edge.
  task automatic model_edge();
    int digit;
    logic wrap;
    logic blank;
    logic [3:0] nib;
    if (!en) begin
      cnt = -1;
      if (load) begin m_disp = data; m_dp = dp_in; m_pend = 1'b0; end
      e_seg = '0; e_sel = '0; e_frame = 1'b0;
    end else begin
      cnt++;
      wrap = (cnt > 0) && (cnt % (ND * SD) == 0);
      if (wrap && load) begin
        m_disp = data; m_dp = dp_in; m_pend = 1'b0;
      end else if (wrap && m_pend) begin
        m_disp = m_shad; m_dp = m_sdp; m_pend = 1'b0;
      end else if (load) begin
        m_shad = data; m_sdp = dp_in; m_pend = 1'b1;
      end
      digit   = (cnt / SD) % ND;
      nib     = 4'((m_disp >> (4 * digit)) & 16'hF);
      blank   = lzb && (digit > 0) && ((m_disp >> (4 * digit)) == 16'h0);
      e_seg   = {blank ? 7'b0 : tbl[nib], m_dp[digit]};
      e_sel   = 4'(1 << digit);
      e_frame = wrap;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("seg", 32'(seg), 32'(e_seg));
    check("digit_sel", 32'(digit_sel), 32'(e_sel));
    check("frame", 32'(frame), 32'(e_frame));
    check("pending", 32'(pending), 32'(m_pend));
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_sel", 32'(digit_sel), 32'h0);
    check("rst_frame", 32'(frame), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    #2;
    rst_n = 1'b1;
  endtask

  // Load with scan stopped, then scan one frame checking each digit against constants.
  task automatic scan_check(input string tag, input logic [15:0] d, input logic [3:0] dp,
                            input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    logic [7:0] exp_s [4];
    exp_s[0] = s0; exp_s[1] = s1; exp_s[2] = s2; exp_s[3] = s3;
    en = 1'b0; load = 1'b1; data = d; dp_in = dp;
    step();
    load = 1'b0; en = 1'b1;
    for (int k = 0; k < 17; k++) begin
      step();
      check({tag, "_seg"}, 32'(seg), 32'(exp_s[(k / 4) % 4]));
      check({tag, "_sel"}, 32'(digit_sel), 32'(1 << ((k / 4) % 4)));
      check({tag, "_frame"}, 32'(frame), 32'(k == 16));
    end
  endtask

  initial begin
    tbl[0]  = 7'b1111110; tbl[1]  = 7'b0110000; tbl[2]  = 7'b1101101; tbl[3]  = 7'b1111001;
    tbl[4]  = 7'b0110011; tbl[5]  = 7'b1011011; tbl[6]  = 7'b1011111; tbl[7]  = 7'b1110000;
    tbl[8]  = 7'b1111111; tbl[9]  = 7'b1111011; tbl[10] = 7'b1110111; tbl[11] = 7'b0011111;
    tbl[12] = 7'b0001101; tbl[13] = 7'b0111101; tbl[14] = 7'b1001111; tbl[15] = 7'b1000111;

    rst_n = 1'b0; en = 1'b0; load = 1'b0; lzb = 1'b0; data = '0; dp_in = '0;
    model_reset();
    #12;
    rst_n = 1'b1;

    // Basic scan and frame pulse.
    scan_check("scan1234", 16'h1234, 4'b0000, 8'b01100110, 8'b11110010, 8'b11011010,
               8'b01100000);

    // Reset while scanning.
    for (int k = 0; k < 5; k++) step();
    async_reset();
    step();

    // Leading-zero blanking and decimal point on a blanked digit.
    lzb = 1'b1;
    scan_check("lzb0070", 16'h0070, 4'b0000, 8'b11111100, 8'b11100000, 8'h00, 8'h00);
    scan_check("lzb0000", 16'h0000, 4'b0000, 8'b11111100, 8'h00, 8'h00, 8'h00);
    scan_check("dp0005", 16'h0005, 4'b0100, 8'b10110110, 8'h00, 8'b00000001, 8'h00);
    lzb = 1'b0;

    // Frame-synchronous load: ABCD during digit 1 is held back until wrap.
    en = 1'b0; load = 1'b1; data = 16'h1234; dp_in = '0;
    step();
    load = 1'b0; en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      load = (k == 5);
      data = (k == 5) ? 16'hABCD : 16'h0000;
      step();
      if (k == 5)  check("shadow_pending", 32'(pending), 32'h1);
      if (k == 9)  check("shadow_d2", 32'(seg), 32'(8'b11011010));
      if (k == 13) check("shadow_d3", 32'(seg), 32'(8'b01100000));
    end
    load = 1'b0;
    step();
    check("wrap_frame", 32'(frame), 32'h1);
    check("wrap_pending", 32'(pending), 32'h0);
    check("wrap_seg_d", 32'(seg), 32'(8'b01111010));

    // Enable dropped during digit 2, then restored.
    for (int k = 0; k < 9; k++) step();
    en = 1'b0;
    step();
    check("en_off_seg", 32'(seg), 32'h0);
    check("en_off_sel", 32'(digit_sel), 32'h0);
    en = 1'b1;
    step();
    check("en_on_sel", 32'(digit_sel), 32'h1);
    check("en_on_seg", 32'(seg), 32'(8'b01111010));

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      en   = ($urandom_range(0, 99) < 98);
      load = ($urandom_range(0, 99) < 6);
      for (int n = 0; n < 4; n++) begin
        data[n*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      dp_in = 4'($urandom);
      if ($urandom_range(0, 49) == 0) lzb = ~lzb;
      if ($urandom_range(0, 599) == 0) async_reset();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
